vc_allocator: RTL and testbench
===============================

Name: vc_allocator

Overview:
- Router-level virtual channel allocator.
- Shares the downstream VCs of every output port among all input VCs that are in the VA stage.
- Grants one free downstream VC per output port per cycle, using round-robin arbitration, and tracks ownership until the packet's tail leaves.
- Sits between the per-input-VC input buffers (vc_request / vc_valid / vc_new / vc_allocatable) and the switch allocator.

Parameters:
- PORT_NUM, default 5, number of router ports (input and output).
- VC_NUM, default 2, VCs per port. VC_SIZE = $clog2(VC_NUM) comes from noc_pkg.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- request_i  in  PORT_NUM*VC_NUM  VA request per input VC. Index k = port*VC_NUM + vc.
- out_port_i  in  PORT_NUM*VC_NUM x port_t  requested output port per input VC.
- release_i  in  PORT_NUM*VC_NUM  one-cycle pulse: input VC k has forwarded its tail; free the downstream VC it owns.
- vc_valid_o  out  PORT_NUM*VC_NUM  grant to input VC k, this cycle.
- vc_new_o  out  PORT_NUM*VC_NUM x VC_SIZE  granted downstream VC id. Meaningful only with vc_valid_o.
- error_o  out  1  registered protocol-error pulse.

Behaviour:
State:
- free[PORT_NUM][VC_NUM]: downstream VC availability.
- owner_valid[k], owner_port[k], owner_vc[k]: the downstream VC held by each input VC.
- rr_ptr[PORT_NUM]: round-robin pointers, each 0..PORT_NUM*VC_NUM-1.

Reset (synchronous, rst high at posedge):
- All free = 1, all owner_valid = 0, all rr_ptr = 0, error_o = 0.
- vc_valid_o reads 0 during and after reset, because no state is owned.

Grant, combinational in the same cycle as the request (zero-cycle latency):
- Per output port p, the candidates are input VCs k with request_i[k], out_port_i[k]==p and !owner_valid[k].
- If any candidate exists and at least one free[p][*] is set:
  - Winner = first candidate at or after rr_ptr[p], wrapping modulo PORT_NUM*VC_NUM.
  - Assigned VC = lowest-index free VC of port p.
  - vc_valid_o[winner] = 1, vc_new_o[winner] = assigned VC.
- At most one grant per output port per cycle. Different output ports grant independently in the same cycle.
- No grant (no candidate, or all VCs busy): rr_ptr[p] is unchanged.

Update at posedge, for each grant:
- free[p][v] <= 0.
- owner_* set.
- rr_ptr[p] <= winner+1 modulo PORT_NUM*VC_NUM.

Release:
- release_i[k] with owner_valid[k] sets free[owner_port[k]][owner_vc[k]] <= 1 and owner_valid[k] <= 0.
- A VC released in cycle t is grantable from cycle t+1, never in cycle t. The same input VC may re-request from t+1.

Errors (error_o pulses high for one cycle in the following cycle):
- request_i[k] while owner_valid[k]: the request is ignored.
- release_i[k] while !owner_valid[k]: ignored.
- release_i[k] and request_i[k] both high in the same cycle: release processed, request ignored.

Non-requesting VCs: vc_new_o = 0.

Reset mid-operation: all ownership is discarded and every downstream VC becomes free.

Optional Feature:
- Macro: VC_ALLOC_FIXED_PRIO_EN.
- Defined: arbitration is fixed-priority; the lowest candidate index k wins. rr_ptr is not instantiated.
- Undefined: round-robin as described above.
- Grant, release and error behaviour are identical in both cases.

Decomposition:
- noc_pkg holds PORT_NUM, VC_NUM, VC_SIZE and port_t. Add a localparam-style constant VC_TOTAL = PORT_NUM*VC_NUM.
- One sub-module, rr_arbiter:
  - Parameter N; inputs request[N], ptr, enable.
  - Output one-hot grant[N], combinational.
  - Instantiated once per output port. Pointer storage stays in vc_allocator.

Test Plan (PORT_NUM=5, VC_NUM=2):
- Reset, then request_i[0] with out_port_i[0]=EAST → same cycle vc_valid_o[0]=1, vc_new_o[0]=0. Next cycle, request_i[2] to EAST → vc_new_o[2]=1.
- Input VCs 0, 2 and 4 request EAST together, all VCs free → only vc_valid_o[0]. Cycle 2, with 0 dropped: k=2 granted VC1. Cycle 3: no EAST VC free, so no grant and rr_ptr stays 3.
- EAST full, release_i[0] pulsed while request_i[4] is held → no grant in the release cycle. Next cycle vc_valid_o[4]=1, vc_new_o[4]=0.
- Requests to EAST (k=0) and LOCAL (k=1) in the same cycle → both granted VC0 in that cycle.
- Fairness: k=0 and k=6 request EAST continuously, each releasing one cycle after its grant → grants alternate 0, 6, 0, 6. With VC_ALLOC_FIXED_PRIO_EN, k=0 wins whenever both are pending.
- release_i[3] with no ownership → error_o=1 for exactly one cycle, free bitmap unchanged. rst asserted while VCs are held → following cycle all grants available again, error_o=0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router constants and the output-port type
package noc_pkg;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_SIZE  = $clog2(VC_NUM);
    localparam int VC_TOTAL = PORT_NUM * VC_NUM;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_t;

endpackage

// File: rtl/vc_allocator_rr_arbiter.sv
// rtl/vc_allocator_rr_arbiter.sv - combinational one-hot arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  request,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (enable && !found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// rtl/vc_allocator.sv - router VC allocator; VC_ALLOC_FIXED_PRIO_EN selects fixed-priority arbitration
module vc_allocator
    import noc_pkg::port_t;
#(
    parameter int PORT_NUM = noc_pkg::PORT_NUM,
    parameter int VC_NUM   = noc_pkg::VC_NUM,
    localparam int VC_TOTAL = PORT_NUM * VC_NUM,
    localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_TOTAL-1:0] request_i,
    input  port_t               out_port_i [VC_TOTAL],
    input  logic [VC_TOTAL-1:0] release_i,
    output logic [VC_TOTAL-1:0] vc_valid_o,
    output logic [VC_SIZE-1:0]  vc_new_o [VC_TOTAL],
    output logic                error_o
);

    localparam int PTR_W = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;

    logic [VC_NUM-1:0]   free [PORT_NUM];
    logic [VC_TOTAL-1:0] owner_valid;
    port_t               owner_port [VC_TOTAL];
    logic [VC_SIZE-1:0]  owner_vc [VC_TOTAL];

    logic [VC_TOTAL-1:0] cand [PORT_NUM];
    logic [VC_TOTAL-1:0] grant [PORT_NUM];
    logic [PTR_W-1:0]    arb_ptr [PORT_NUM];
    logic [VC_SIZE-1:0]  pick_vc [PORT_NUM];
    logic [PORT_NUM-1:0] port_en;
    logic                err_next;

    // A releasing input VC may not request in the same cycle; held VCs never re-request.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            cand[p]    = '0;
            pick_vc[p] = '0;
            for (int k = 0; k < VC_TOTAL; k++) begin
                cand[p][k] = request_i[k] && !release_i[k] && !owner_valid[k]
                             && (int'(out_port_i[k]) == p);
            end
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (free[p][v]) pick_vc[p] = VC_SIZE'(v);
            end
            port_en[p] = !rst && (|free[p]);
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        rr_arbiter #(.N(VC_TOTAL)) u_arb (
            .request (cand[p]),
            .ptr     (arb_ptr[p]),
            .enable  (port_en[p]),
            .grant   (grant[p])
        );
    end

`ifdef VC_ALLOC_FIXED_PRIO_EN
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) arb_ptr[p] = '0;
    end
`else
    logic [PTR_W-1:0] rr_ptr [PORT_NUM];

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) arb_ptr[p] = rr_ptr[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PORT_NUM; p++) rr_ptr[p] <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int k = 0; k < VC_TOTAL; k++) begin
                    if (grant[p][k]) rr_ptr[p] <= (k == VC_TOTAL - 1) ? '0 : PTR_W'(k + 1);
                end
            end
        end
    end
`endif

    always_comb begin
        vc_valid_o = '0;
        for (int k = 0; k < VC_TOTAL; k++) vc_new_o[k] = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int k = 0; k < VC_TOTAL; k++) begin
                if (grant[p][k]) begin
                    vc_valid_o[k] = 1'b1;
                    vc_new_o[k]   = pick_vc[p];
                end
            end
        end
        err_next = (|(request_i & owner_valid)) || (|(release_i & ~owner_valid))
                   || (|(release_i & request_i));
    end

    // Releases and grants never touch the same VC in one cycle: a grant needs a free VC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PORT_NUM; p++) free[p] <= '1;
            for (int k = 0; k < VC_TOTAL; k++) begin
                owner_port[k] <= port_t'(0);
                owner_vc[k]   <= '0;
            end
            owner_valid <= '0;
            error_o     <= 1'b0;
        end else begin
            error_o <= err_next;
            for (int k = 0; k < VC_TOTAL; k++) begin
                if (release_i[k] && owner_valid[k]) begin
                    owner_valid[k] <= 1'b0;
                    for (int p = 0; p < PORT_NUM; p++) begin
                        for (int v = 0; v < VC_NUM; v++) begin
                            if (int'(owner_port[k]) == p && int'(owner_vc[k]) == v)
                                free[p][v] <= 1'b1;
                        end
                    end
                end
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int k = 0; k < VC_TOTAL; k++) begin
                    if (grant[p][k]) begin
                        free[p][pick_vc[p]] <= 1'b0;
                        owner_valid[k]      <= 1'b1;
                        owner_port[k]       <= port_t'(p);
                        owner_vc[k]         <= pick_vc[p];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_allocator.sv
// tb/tb_vc_allocator.sv - directed and randomized bench for vc_allocator
module tb_vc_allocator;
    import noc_pkg::*;

    localparam int P  = noc_pkg::PORT_NUM;
    localparam int V  = noc_pkg::VC_NUM;
    localparam int T  = noc_pkg::VC_TOTAL;
    localparam int VS = noc_pkg::VC_SIZE;

    logic          clk;
    logic          rst;
    logic [T-1:0]  req_v;
    logic [T-1:0]  rel_v;
    port_t         port_sel [T];
    logic [T-1:0]  vc_valid;
    logic [VS-1:0] vc_new [T];
    logic          error;

    vc_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .request_i  (req_v),
        .out_port_i (port_sel),
        .release_i  (rel_v),
        .vc_valid_o (vc_valid),
        .vc_new_o   (vc_new),
        .error_o    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: which downstream VCs are taken, who holds what, where each port's search starts.
    bit           m_free  [P][V];
    bit [T-1:0]   m_own;
    int           m_own_p [T];
    int           m_own_vc[T];
    int           m_ptr   [P];
    bit           m_err;
    bit           m_known = 1'b0;

    logic [T-1:0] exp_valid;
    int           exp_new [T];
    int           exp_win [P];
    int           exp_vc  [P];
    bit           exp_err_next;

    logic [T-1:0] obs_valid;
    int           obs_new [T];
    logic         obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_eval();
        exp_valid = '0;
        for (int k = 0; k < T; k++) exp_new[k] = 0;
        for (int p = 0; p < P; p++) begin
            int start;
            exp_win[p] = -1;
            exp_vc[p]  = -1;
            for (int v = V - 1; v >= 0; v--) if (m_free[p][v]) exp_vc[p] = v;
`ifdef VC_ALLOC_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr[p];
`endif
            if (!rst && exp_vc[p] >= 0) begin
                for (int i = 0; i < T; i++) begin
                    int k;
                    k = (start + i) % T;
                    if (exp_win[p] < 0 && req_v[k] && !rel_v[k] && !m_own[k]
                        && int'(port_sel[k]) == p) begin
                        exp_win[p]   = k;
                        exp_valid[k] = 1'b1;
                        exp_new[k]   = exp_vc[p];
                    end
                end
            end
        end
        exp_err_next = (|(req_v & m_own)) || (|(rel_v & ~m_own)) || (|(rel_v & req_v));
    endtask

    task automatic model_update();
        if (rst) begin
            for (int p = 0; p < P; p++) begin
                m_ptr[p] = 0;
                for (int v = 0; v < V; v++) m_free[p][v] = 1'b1;
            end
            m_own   = '0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            m_err = exp_err_next;
            for (int k = 0; k < T; k++) begin
                if (rel_v[k] && m_own[k]) begin
                    m_own[k] = 1'b0;
                    m_free[m_own_p[k]][m_own_vc[k]] = 1'b1;
                end
            end
            for (int p = 0; p < P; p++) begin
                if (exp_win[p] >= 0) begin
                    m_free[p][exp_vc[p]]  = 1'b0;
                    m_own[exp_win[p]]     = 1'b1;
                    m_own_p[exp_win[p]]   = p;
                    m_own_vc[exp_win[p]]  = exp_vc[p];
                    m_ptr[p]              = (exp_win[p] + 1) % T;
                end
            end
        end
    endtask

    task automatic step(input logic [T-1:0] rq, input logic [T-1:0] rl, input logic r);
        logic [63:0] got_pk;
        logic [63:0] exp_pk;
        req_v = rq;
        rel_v = rl;
        rst   = r;
        @(negedge clk);
        model_eval();
        obs_valid = vc_valid;
        obs_err   = error;
        got_pk = '0;
        exp_pk = '0;
        for (int k = 0; k < T; k++) begin
            obs_new[k] = int'(vc_new[k]);
            if (exp_valid[k] || !rq[k]) begin
                got_pk = got_pk | (64'(vc_new[k]) << (k * VS));
                exp_pk = exp_pk | (64'(exp_new[k]) << (k * VS));
            end
        end
        check("vc_valid", 64'(vc_valid), 64'(exp_valid));
        check("vc_new", got_pk, exp_pk);
        if (m_known) check("error", 64'(error), 64'(m_err));
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        logic [T-1:0] rq;
        logic [T-1:0] rl;
        int           seq[$];
        int           exp_seq[4];
        exp_seq = '{0, 6, 0, 6};
        req_v = '0;
        rel_v = '0;
        rst   = 1'b1;
        for (int k = 0; k < T; k++) port_sel[k] = EAST;
        #1;

        // Same-cycle grant, then the second EAST VC to the next requester
        step('0, '0, 1'b1);
        check("reset_valid", 64'(obs_valid), 64'd0);
        step(T'(1), '0, 1'b0);
        check("t1_valid0", 64'(obs_valid[0]), 64'd1);
        check("t1_new0", 64'(obs_new[0]), 64'd0);
        step(T'(1) << 2, '0, 1'b0);
        check("t1_new2", 64'(obs_new[2]), 64'd1);

        // Three requesters, one grant per cycle, then EAST exhausted
        step('0, '0, 1'b1);
        step(T'('b10101), '0, 1'b0);
        check("t2_only0", 64'(obs_valid), 64'd1);
        step(T'('b10100), '0, 1'b0);
        check("t2_k2", 64'(obs_valid), 64'd4);
        check("t2_k2_vc", 64'(obs_new[2]), 64'd1);
        step(T'('b10000), '0, 1'b0);
        check("t2_full", 64'(obs_valid), 64'd0);

        // Released VC is not grantable in the release cycle
        step(T'('b10000), T'(1), 1'b0);
        check("t3_rel_cycle", 64'(obs_valid), 64'd0);
        step(T'('b10000), '0, 1'b0);
        check("t3_k4", 64'(obs_valid[4]), 64'd1);
        check("t3_k4_vc", 64'(obs_new[4]), 64'd0);
        check("t3_err", 64'(obs_err), 64'd0);

        // Independent output ports grant in the same cycle
        step('0, '0, 1'b1);
        port_sel[1] = LOCAL;
        step(T'('b11), '0, 1'b0);
        check("t4_both", 64'(obs_valid), 64'd3);
        check("t4_new1", 64'(obs_new[1]), 64'd0);

        // Two contenders, each releasing one cycle after its grant
        step('0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rq = (~m_own) & T'('b1000001);
            rl = m_own & T'('b1000001);
            step(rq, rl, 1'b0);
            if (obs_valid[0]) seq.push_back(0);
            else if (obs_valid[6]) seq.push_back(6);
        end
        check("t5_count", 64'(seq.size()), 64'd4);
        for (int i = 0; i < 4 && i < seq.size(); i++) check("t5_order", 64'(seq[i]), 64'(exp_seq[i]));

        // Spurious release, then reset while VCs are held
        step('0, '0, 1'b1);
        step('0, T'(1) << 3, 1'b0);
        step('0, '0, 1'b0);
        check("t6_err_hi", 64'(obs_err), 64'd1);
        step(T'(1), '0, 1'b0);
        check("t6_err_lo", 64'(obs_err), 64'd0);
        check("t6_free_vc0", 64'(obs_new[0]), 64'd0);
        step(T'(1) << 2, '0, 1'b0);
        step('0, '0, 1'b1);
        step(T'(1), '0, 1'b0);
        check("t6_after_rst", 64'(obs_valid), 64'd1);
        check("t6_after_rst_vc", 64'(obs_new[0]), 64'd0);
        check("t6_after_rst_err", 64'(obs_err), 64'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rq = '0;
            rl = '0;
            for (int k = 0; k < T; k++) begin
                port_sel[k] = port_t'($urandom_range(0, P - 1));
                if ($urandom_range(0, 9) < 4) rq[k] = 1'b1;
                if (m_own[k] && $urandom_range(0, 3) == 0) rl[k] = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) rl[$urandom_range(0, T - 1)] = 1'b1;
            step(rq, rl, ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
